zbuffer_pixel_writer: RTL and testbench

//  Downstream consumer of the span rasterizer's one-cycle plot pulses (x, y, z per pixel).

---
 rtl/zbuffer_pixel_writer_if.sv | 36 +++
 rtl/zbuffer_pixel_writer.sv | 136 +++++++++++++
 tb/tb_zbuffer_pixel_writer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zbuffer_pixel_writer_if.sv
// Pixel-writer bus: plot/clear inputs from the span stage, z-buffer and framebuffer RAM ports, status.
// The writer connects through the slave view; whatever drives plots and models the RAMs uses master.
interface zbuffer_pixel_writer_if #(
    parameter int AW = 19
);
    logic          plot;
    logic [10:0]   x;
    logic [10:0]   y;
    logic [15:0]   z_in;
    logic [23:0]   color;
    logic          clear;
    logic          busy;
    logic          overflow;
    logic [AW-1:0] zb_addr;
    logic          zb_rd;
    logic [15:0]   zb_rdata;
    logic          zb_wr;
    logic [15:0]   zb_wdata;
    logic [AW-1:0] fb_addr;
    logic          fb_wr;
    logic [23:0]   fb_wdata;
    logic          drawn;
    logic          clear_done;

    modport slave (
        input  plot, x, y, z_in, color, clear, zb_rdata,
        output busy, overflow, zb_addr, zb_rd, zb_wr, zb_wdata,
               fb_addr, fb_wr, fb_wdata, drawn, clear_done
    );

    modport master (
        output plot, x, y, z_in, color, clear, zb_rdata,
        input  busy, overflow, zb_addr, zb_rd, zb_wr, zb_wdata,
               fb_addr, fb_wr, fb_wdata, drawn, clear_done
    );
endinterface

// File: rtl/zbuffer_pixel_writer.sv
// Z-buffer pixel writer: queues plotted pixels, depth-tests each against the stored z and writes
// closer pixels to z-buffer and framebuffer; also sweeps the z-buffer to far depth on request.
//   state | meaning
//   IDLE  | pop next queued pixel, or start a pending clear once the queue is empty
//   RD    | z-buffer read issued for the current pixel
//   CMP   | stored depth available, compare with incoming z
//   WR    | write z and color for a pixel that passed
//   CLR   | write far depth to one address per cycle
module zbuffer_pixel_writer #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 19
) (
    input  logic clk_i,
    input  logic reset_i,
    zbuffer_pixel_writer_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int EW = 11 + 11 + 16 + 24;
    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);
    localparam logic [CW:0]   FIFO_FULL = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CMP, S_WR, S_CLR} state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   fifo_q [FIFO_DEPTH];
    logic [CW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW:0]     count_q;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     z_q, z_d;
    logic [23:0]     color_q, color_d;
    logic            clear_pending_q;
    logic            overflow_q;

    logic            fifo_empty, fifo_full, push, pop;
    logic [10:0]     head_x, head_y;
    logic [15:0]     head_z;
    logic [23:0]     head_color;
    logic            in_range;
    logic [AW-1:0]   pix_addr;
    logic            clr_last;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL);
    // A full queue drops the plot even if a pop happens in the same cycle.
    assign push       = bus.plot && !fifo_full;

    assign {head_x, head_y, head_z, head_color} = fifo_q[rd_ptr_q];
    assign in_range = (32'(head_x) < 32'(WIDTH)) && (32'(head_y) < 32'(HEIGHT));
    assign pix_addr = AW'(head_y) * AW'(WIDTH) + AW'(head_x);
    assign clr_last = (state_q == S_CLR) && (addr_q == LAST_ADDR);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        z_d     = z_q;
        color_d = color_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear_pending_q && fifo_empty) begin
                    state_d = S_CLR;
                    addr_d  = '0;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                    if (in_range) begin
                        addr_d  = pix_addr;
                        z_d     = head_z;
                        color_d = head_color;
                        state_d = S_RD;
                    end
                end
            end
            S_RD:  state_d = S_CMP;
            S_CMP: state_d = (z_q < bus.zb_rdata) ? S_WR : S_IDLE;
            S_WR:  state_d = S_IDLE;
            S_CLR: begin
                if (clr_last) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            z_q             <= '0;
            color_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            clear_pending_q <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            z_q     <= z_d;
            color_q <= color_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.plot && fifo_full) overflow_q <= 1'b1;
            if (clr_last) begin
                clear_pending_q <= 1'b0;
            end else if (bus.clear && state_q != S_CLR) begin
                clear_pending_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= {bus.x, bus.y, bus.z_in, bus.color};
    end

    assign bus.busy       = (state_q != S_IDLE) || !fifo_empty || clear_pending_q;
    assign bus.overflow   = overflow_q;
    assign bus.zb_addr    = addr_q;
    assign bus.fb_addr    = addr_q;
    assign bus.zb_rd      = (state_q == S_RD);
    assign bus.zb_wr      = (state_q == S_WR) || (state_q == S_CLR);
    assign bus.fb_wr      = (state_q == S_WR);
    assign bus.drawn      = (state_q == S_WR);
    assign bus.clear_done = clr_last;
    assign bus.zb_wdata   = (state_q == S_CLR) ? 16'hFFFF : ((state_q == S_WR) ? z_q : 16'h0000);
    assign bus.fb_wdata   = (state_q == S_WR) ? color_q : 24'h000000;
endmodule

// File: tb/tb_zbuffer_pixel_writer.sv
// Bench for zbuffer_pixel_writer: a full-size 640x480 instance for depth/latency/random checks
// and an 8x4 instance for clear sweeps, queue overflow and reset during a clear.
module tb_zbuffer_pixel_writer;
    logic clk;
    logic rst_big, rst_small;
    int   vectors = 0;
    int   miscompares = 0;

    zbuffer_pixel_writer_if #(.AW(19)) bb ();
    zbuffer_pixel_writer_if #(.AW(5))  sb ();

    zbuffer_pixel_writer #(.WIDTH(640), .HEIGHT(480), .FIFO_DEPTH(4), .AW(19)) dut_big (
        .clk_i(clk), .reset_i(rst_big), .bus(bb));
    zbuffer_pixel_writer #(.WIDTH(8), .HEIGHT(4), .FIFO_DEPTH(4), .AW(5)) dut_small (
        .clk_i(clk), .reset_i(rst_small), .bus(sb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM models with one-cycle read latency; preload shares the big z-buffer write port.
    logic [15:0] zram_big  [0:524287];
    logic [23:0] fbram_big [0:524287];
    logic [15:0] zram_small  [0:31];
    logic [23:0] fbram_small [0:31];
    logic        pre_we;
    logic [18:0] pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (bb.zb_rd) bb.zb_rdata <= zram_big[bb.zb_addr];
        if (bb.zb_wr) zram_big[bb.zb_addr] <= bb.zb_wdata;
        else if (pre_we) zram_big[pre_addr] <= pre_data;
        if (bb.fb_wr) fbram_big[bb.fb_addr] <= bb.fb_wdata;
        if (sb.zb_rd) sb.zb_rdata <= zram_small[sb.zb_addr];
        if (sb.zb_wr) zram_small[sb.zb_addr] <= sb.zb_wdata;
        if (sb.fb_wr) fbram_small[sb.fb_addr] <= sb.fb_wdata;
    end

    logic [58:0] obs_big[$];
    logic [58:0] obs_small[$];
    int zbrd_big = 0, zbwr_big = 0, fbwr_big = 0, drawn_big = 0;
    int drawn_small = 0, cd_small = 0;

    always @(negedge clk) begin
        if (bb.zb_rd) zbrd_big++;
        if (bb.zb_wr) zbwr_big++;
        if (bb.fb_wr) begin
            fbwr_big++;
            obs_big.push_back({bb.fb_addr, bb.zb_wdata, bb.fb_wdata});
            vectors++;
            if (bb.zb_wr !== 1'b1 || bb.drawn !== 1'b1 || bb.zb_addr !== bb.fb_addr) begin
                miscompares++;
                $display("FAIL pair_big: zb_wr=%0b drawn=%0b zb_addr=%0d fb_addr=%0d, required 1 1 and equal addresses",
                         bb.zb_wr, bb.drawn, bb.zb_addr, bb.fb_addr);
            end
        end
        if (bb.drawn) drawn_big++;
        if (sb.fb_wr) obs_small.push_back({14'd0, sb.fb_addr, sb.zb_wdata, sb.fb_wdata});
        if (sb.drawn) drawn_small++;
        if (sb.clear_done) cd_small++;
    end

    task automatic pre_big(input int a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = 19'(a); pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic plot_big(input int px, input int py, input logic [15:0] pz, input logic [23:0] pc);
        bb.plot = 1'b1; bb.x = 11'(px); bb.y = 11'(py); bb.z_in = pz; bb.color = pc;
        @(negedge clk);
        bb.plot = 1'b0;
    endtask

    task automatic pulse_clear_small();
        sb.clear = 1'b1;
        @(negedge clk);
        sb.clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_big = 1'b1; rst_small = 1'b1;
        repeat (3) @(negedge clk);
        rst_big = 1'b0; rst_small = 1'b0;
        vectors++;
        if ({bb.busy, bb.overflow, bb.zb_rd, bb.zb_wr, bb.fb_wr, bb.drawn, bb.clear_done} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_big_flags: got %b, required 0000000",
                     {bb.busy, bb.overflow, bb.zb_rd, bb.zb_wr, bb.fb_wr, bb.drawn, bb.clear_done});
        end
        vectors++;
        if (bb.zb_addr !== 19'd0 || bb.fb_addr !== 19'd0 || bb.zb_wdata !== 16'd0 || bb.fb_wdata !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_big_buses: zb_addr=%0d fb_addr=%0d zb_wdata=%h fb_wdata=%h, required all 0",
                     bb.zb_addr, bb.fb_addr, bb.zb_wdata, bb.fb_wdata);
        end
        vectors++;
        if ({sb.busy, sb.overflow, sb.zb_rd, sb.zb_wr, sb.fb_wr, sb.drawn, sb.clear_done} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_small_flags: got %b, required 0000000",
                     {sb.busy, sb.overflow, sb.zb_rd, sb.zb_wr, sb.fb_wr, sb.drawn, sb.clear_done});
        end
    endtask

    task automatic test_latency_draw();
        pre_big(1283, 16'h8000);
        bb.plot = 1'b1; bb.x = 11'd3; bb.y = 11'd2; bb.z_in = 16'h1000; bb.color = 24'hFF0000;
        @(negedge clk);
        bb.plot = 1'b0;
        vectors++;
        if (bb.zb_rd !== 1'b0) begin
            miscompares++; $display("FAIL lat_cyc1_rd: zb_rd=%b, required 0", bb.zb_rd);
        end
        @(negedge clk);
        vectors++;
        if (bb.zb_rd !== 1'b1 || bb.zb_addr !== 19'd1283) begin
            miscompares++; $display("FAIL lat_cyc2_rd: zb_rd=%b addr=%0d, required 1 addr 1283", bb.zb_rd, bb.zb_addr);
        end
        @(negedge clk);
        vectors++;
        if ({bb.zb_rd, bb.zb_wr, bb.fb_wr, bb.drawn} !== 4'b0000) begin
            miscompares++; $display("FAIL lat_cyc3_idle: strobes=%b, required 0000", {bb.zb_rd, bb.zb_wr, bb.fb_wr, bb.drawn});
        end
        @(negedge clk);
        vectors++;
        if ({bb.zb_wr, bb.fb_wr, bb.drawn} !== 3'b111) begin
            miscompares++; $display("FAIL lat_cyc4_wr: zb_wr/fb_wr/drawn=%b, required 111", {bb.zb_wr, bb.fb_wr, bb.drawn});
        end
        vectors++;
        if (bb.zb_wdata !== 16'h1000 || bb.fb_wdata !== 24'hFF0000 || bb.fb_addr !== 19'd1283) begin
            miscompares++;
            $display("FAIL lat_cyc4_data: zb_wdata=%h fb_wdata=%h fb_addr=%0d, required 1000 ff0000 1283",
                     bb.zb_wdata, bb.fb_wdata, bb.fb_addr);
        end
        @(negedge clk);
        vectors++;
        if (bb.busy !== 1'b0 || bb.drawn !== 1'b0) begin
            miscompares++; $display("FAIL lat_after: busy=%b drawn=%b, required 0 0", bb.busy, bb.drawn);
        end
        vectors++;
        if (zram_big[1283] !== 16'h1000 || fbram_big[1283] !== 24'hFF0000) begin
            miscompares++;
            $display("FAIL lat_ram: z=%h color=%h, required 1000 ff0000", zram_big[1283], fbram_big[1283]);
        end
    endtask

    task automatic test_depth_fail();
        int rd0, wr0, dr0;
        rd0 = zbrd_big; wr0 = zbwr_big; dr0 = drawn_big;
        plot_big(3, 2, 16'h1000, 24'h00FF00);
        repeat (6) @(negedge clk);
        plot_big(3, 2, 16'h2000, 24'h0000FF);
        repeat (6) @(negedge clk);
        vectors++;
        if (zbrd_big - rd0 != 2) begin
            miscompares++; $display("FAIL depth_reads: %0d reads, required 2", zbrd_big - rd0);
        end
        vectors++;
        if (zbwr_big != wr0 || drawn_big != dr0) begin
            miscompares++;
            $display("FAIL depth_nowrite: %0d writes %0d drawn, required 0 0", zbwr_big - wr0, drawn_big - dr0);
        end
        vectors++;
        if (zram_big[1283] !== 16'h1000 || fbram_big[1283] !== 24'hFF0000) begin
            miscompares++;
            $display("FAIL depth_ram: z=%h color=%h, required 1000 ff0000", zram_big[1283], fbram_big[1283]);
        end
    endtask

    task automatic test_range();
        int rd0, wr0, fw0;
        rd0 = zbrd_big; wr0 = zbwr_big; fw0 = fbwr_big;
        plot_big(640, 0, 16'h0000, 24'h111111);
        repeat (5) @(negedge clk);
        plot_big(5, 480, 16'h0000, 24'h222222);
        repeat (5) @(negedge clk);
        vectors++;
        if (zbrd_big != rd0 || zbwr_big != wr0 || fbwr_big != fw0 || bb.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL range_discard: rd=%0d zwr=%0d fwr=%0d busy=%b, required 0 0 0 0",
                     zbrd_big - rd0, zbwr_big - wr0, fbwr_big - fw0, bb.busy);
        end
        pre_big(307199, 16'hFFFF);
        plot_big(639, 479, 16'h1234, 24'hABCDEF);
        @(negedge clk);
        vectors++;
        if (bb.zb_rd !== 1'b1 || bb.zb_addr !== 19'd307199) begin
            miscompares++; $display("FAIL range_corner_rd: zb_rd=%b addr=%0d, required 1 addr 307199", bb.zb_rd, bb.zb_addr);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (zram_big[307199] !== 16'h1234 || fbram_big[307199] !== 24'hABCDEF) begin
            miscompares++;
            $display("FAIL range_corner_wr: z=%h color=%h, required 1234 abcdef", zram_big[307199], fbram_big[307199]);
        end
    endtask

    task automatic test_random();
        logic [15:0] ref_z [int];
        logic [58:0] exp_q[$];
        int px, py, a, k, dr0;
        logic [15:0] pz;
        logic [23:0] pc;
        for (int yy = 0; yy < 4; yy++) begin
            for (int xx = 0; xx < 8; xx++) begin
                pz = 16'($urandom);
                pre_big(yy * 640 + xx, pz);
                ref_z[yy * 640 + xx] = pz;
            end
        end
        obs_big.delete();
        dr0 = drawn_big;
        for (int n = 0; n < 60; n++) begin
            px = ($urandom_range(0, 9) == 0) ? 640 + int'($urandom_range(0, 1407)) : int'($urandom_range(0, 7));
            py = ($urandom_range(0, 9) == 0) ? 480 + int'($urandom_range(0, 1567)) : int'($urandom_range(0, 3));
            pz = 16'($urandom);
            pc = 24'($urandom);
            if (px < 640 && py < 480) begin
                a = py * 640 + px;
                if (pz < ref_z[a]) begin
                    exp_q.push_back({19'(a), pz, pc});
                    ref_z[a] = pz;
                end
            end
            plot_big(px, py, pz, pc);
            repeat ($urandom_range(3, 7)) @(negedge clk);
        end
        k = 0;
        while (bb.busy && k < 100) begin @(negedge clk); k++; end
        vectors++;
        if (bb.busy !== 1'b0) begin
            miscompares++; $display("FAIL rand_drain: busy=%b after %0d cycles, required 0", bb.busy, k);
        end
        vectors++;
        if (obs_big.size() != exp_q.size()) begin
            miscompares++; $display("FAIL rand_count: %0d writes, required %0d", obs_big.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_big.size(); i++) begin
            vectors++;
            if (obs_big[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL rand_write[%0d]: got %h, required %h", i, obs_big[i], exp_q[i]);
            end
        end
        vectors++;
        if (drawn_big - dr0 != exp_q.size()) begin
            miscompares++; $display("FAIL rand_drawn: %0d pulses, required %0d", drawn_big - dr0, exp_q.size());
        end
    endtask

    task automatic test_clear();
        int k, cd0, bad;
        cd0 = cd_small;
        pulse_clear_small();
        k = 0;
        while (!sb.zb_wr && k < 8) begin @(negedge clk); k++; end
        vectors++;
        if (sb.zb_wr !== 1'b1) begin
            miscompares++; $display("FAIL clr_start: zb_wr=%b after %0d cycles, required 1", sb.zb_wr, k);
            return;
        end
        for (int i = 0; i < 32; i++) begin
            vectors++;
            if (sb.zb_wr !== 1'b1 || sb.zb_addr !== 5'(i) || sb.zb_wdata !== 16'hFFFF || sb.fb_wr !== 1'b0 ||
                sb.clear_done !== (i == 31) || sb.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL clr_step[%0d]: zb_wr=%b addr=%0d data=%h fb_wr=%b done=%b busy=%b, required 1 %0d ffff 0 %0b 1",
                         i, sb.zb_wr, sb.zb_addr, sb.zb_wdata, sb.fb_wr, sb.clear_done, sb.busy, i, (i == 31));
            end
            @(negedge clk);
        end
        vectors++;
        if (sb.busy !== 1'b0 || sb.zb_wr !== 1'b0 || sb.clear_done !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_end: busy=%b zb_wr=%b done=%b, required 0 0 0", sb.busy, sb.zb_wr, sb.clear_done);
        end
        vectors++;
        if (cd_small - cd0 != 1) begin
            miscompares++; $display("FAIL clr_done_count: %0d pulses, required 1", cd_small - cd0);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (zram_small[i] !== 16'hFFFF) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++; $display("FAIL clr_ram: %0d entries not ffff, required 0", bad);
        end
    endtask

    task automatic test_plot_during_clear();
        int k;
        obs_small.delete();
        pulse_clear_small();
        k = 0;
        while (!sb.zb_wr && k < 8) begin @(negedge clk); k++; end
        sb.plot = 1'b1; sb.x = 11'd2; sb.y = 11'd2; sb.z_in = 16'h0100; sb.color = 24'h123456;
        @(negedge clk);
        sb.plot = 1'b0;
        k = 0;
        while (!sb.clear_done && k < 40) begin @(negedge clk); k++; end
        vectors++;
        if (sb.clear_done !== 1'b1) begin
            miscompares++; $display("FAIL pdc_done: clear_done=%b after %0d cycles, required 1", sb.clear_done, k);
        end
        vectors++;
        if (obs_small.size() != 0) begin
            miscompares++; $display("FAIL pdc_early: %0d draws before clear_done, required 0", obs_small.size());
        end
        k = 0;
        while (sb.busy && k < 20) begin @(negedge clk); k++; end
        vectors++;
        if (obs_small.size() != 1) begin
            miscompares++; $display("FAIL pdc_count: %0d draws, required 1", obs_small.size());
        end else begin
            vectors++;
            if (obs_small[0] !== {14'd0, 5'd18, 16'h0100, 24'h123456}) begin
                miscompares++;
                $display("FAIL pdc_write: got %h, required %h", obs_small[0], {14'd0, 5'd18, 16'h0100, 24'h123456});
            end
        end
    endtask

    task automatic test_overflow();
        logic [58:0] px [6];
        int k, dr0;
        logic [15:0] pz;
        logic [23:0] pc;
        obs_small.delete();
        dr0 = drawn_small;
        vectors++;
        if (sb.overflow !== 1'b0) begin
            miscompares++; $display("FAIL ovf_pre: overflow=%b, required 0", sb.overflow);
        end
        for (int i = 0; i < 6; i++) begin
            pz = 16'($urandom_range(0, 16'hFFFE));
            pc = 24'($urandom);
            px[i] = {14'd0, 5'(8 + i), pz, pc};
            sb.plot = 1'b1; sb.x = 11'(i); sb.y = 11'd1; sb.z_in = pz; sb.color = pc;
            @(negedge clk);
        end
        sb.plot = 1'b0;
        vectors++;
        if (sb.overflow !== 1'b1) begin
            miscompares++; $display("FAIL ovf_set: overflow=%b, required 1", sb.overflow);
        end
        k = 0;
        while (sb.busy && k < 60) begin @(negedge clk); k++; end
        vectors++;
        if (sb.overflow !== 1'b1 || sb.busy !== 1'b0) begin
            miscompares++; $display("FAIL ovf_sticky: overflow=%b busy=%b, required 1 0", sb.overflow, sb.busy);
        end
        vectors++;
        if (drawn_small - dr0 != 5) begin
            miscompares++; $display("FAIL ovf_drawn: %0d pulses, required 5", drawn_small - dr0);
        end
        vectors++;
        if (obs_small.size() != 5) begin
            miscompares++; $display("FAIL ovf_count: %0d writes, required 5", obs_small.size());
        end
        for (int i = 0; i < 5 && i < obs_small.size(); i++) begin
            vectors++;
            if (obs_small[i] !== px[i]) begin
                miscompares++; $display("FAIL ovf_write[%0d]: got %h, required %h", i, obs_small[i], px[i]);
            end
        end
    endtask

    task automatic test_reset_during_clear();
        int k;
        pulse_clear_small();
        k = 0;
        while (!(sb.zb_wr && sb.zb_addr == 5'd10) && k < 40) begin @(negedge clk); k++; end
        vectors++;
        if (sb.zb_wr !== 1'b1 || sb.zb_addr !== 5'd10) begin
            miscompares++; $display("FAIL rdc_reach: zb_wr=%b addr=%0d, required 1 addr 10", sb.zb_wr, sb.zb_addr);
        end
        rst_small = 1'b1;
        @(negedge clk);
        vectors++;
        if ({sb.zb_rd, sb.zb_wr, sb.fb_wr, sb.drawn, sb.clear_done} !== 5'd0) begin
            miscompares++;
            $display("FAIL rdc_strobes: got %b, required 00000", {sb.zb_rd, sb.zb_wr, sb.fb_wr, sb.drawn, sb.clear_done});
        end
        vectors++;
        if (sb.busy !== 1'b0 || sb.overflow !== 1'b0) begin
            miscompares++; $display("FAIL rdc_status: busy=%b overflow=%b, required 0 0", sb.busy, sb.overflow);
        end
        rst_small = 1'b0;
    endtask

    initial begin
        bb.plot = 1'b0; bb.x = '0; bb.y = '0; bb.z_in = '0; bb.color = '0; bb.clear = 1'b0;
        sb.plot = 1'b0; sb.x = '0; sb.y = '0; sb.z_in = '0; sb.color = '0; sb.clear = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        rst_big = 1'b1; rst_small = 1'b1;
        test_reset();
        test_latency_draw();
        test_depth_fail();
        test_range();
        test_random();
        test_clear();
        test_plot_during_clear();
        test_overflow();
        test_reset_during_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
